// File: rtl/posit_batch_sequencer_pkg.sv
// posit_seq_pkg: shared FSM state type, default sizes and geometry helpers for the posit batch sequencer
package posit_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, WRITE, NEXT, DONE} state_t;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_NBITS = 32;
  localparam int BYTES_PER_WORD = DEF_NBITS / 8;
  localparam int MAX_PAIRS = 2 ** (DEF_ADDR_W - 3);
  function automatic int bytes_per_word(input int nbits);
    return nbits / 8;
  endfunction
  function automatic int max_pairs(input int addr_w);
    return 2 ** (addr_w - 3);
  endfunction
endpackage

// File: rtl/posit_batch_sequencer_if.sv
// posit_batch_sequencer_if: operand-memory read port, result-memory write port and posit unit handshake
//   master: sequencer side (drives addresses, strobes, operands, in_valid)
//   slave : memories + posit unit side (drives readdata, in_ready, out_valid, result)
interface posit_batch_sequencer_if #(parameter int ADDR_W = 12, parameter int NBITS = 32);
  logic [ADDR_W-1:0] src_address;
  logic src_chipselect;
  logic src_clken;
  logic src_write;
  logic [7:0] src_writedata;
  logic [7:0] src_readdata;
  logic [ADDR_W-1:0] dst_address;
  logic dst_chipselect;
  logic dst_clken;
  logic dst_write;
  logic [7:0] dst_writedata;
  logic [NBITS-1:0] pu_num1;
  logic [NBITS-1:0] pu_num2;
  logic pu_in_valid;
  logic pu_in_ready;
  logic pu_out_valid;
  logic [NBITS-1:0] pu_result;
  modport master (
    output src_address, src_chipselect, src_clken, src_write, src_writedata,
    input src_readdata,
    output dst_address, dst_chipselect, dst_clken, dst_write, dst_writedata,
    output pu_num1, pu_num2, pu_in_valid,
    input pu_in_ready, pu_out_valid, pu_result
  );
  modport slave (
    input src_address, src_chipselect, src_clken, src_write, src_writedata,
    output src_readdata,
    input dst_address, dst_chipselect, dst_clken, dst_write, dst_writedata,
    input pu_num1, pu_num2, pu_in_valid,
    output pu_in_ready, pu_out_valid, pu_result
  );
endinterface

// File: rtl/posit_batch_sequencer_byte_gather.sv
// posit_seq_byte_gather: assembles num1/num2 from the little-endian operand byte stream
//   issue   : a read was issued this cycle; its byte returns RD_LAT cycles later
//   rd_data : operand memory read data
//   num1/2  : assembled operands, stable once the last byte is captured
module posit_seq_byte_gather #(parameter int NBITS = 32, parameter int RD_LAT = 1) (
  input logic clk,
  input logic rst,
  input logic issue,
  input logic [7:0] rd_data,
  output logic [NBITS-1:0] num1,
  output logic [NBITS-1:0] num2
);
  logic [RD_LAT-1:0] vld;
  logic [2*NBITS-1:0] lanes;
  // bytes enter at the top and shift down, so after 2W captures the first byte sits in num1[7:0]
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld <= '0;
      lanes <= '0;
    end else begin
      vld <= (vld << 1) | RD_LAT'(issue);
      if (vld[RD_LAT-1]) lanes <= {rd_data, lanes[2*NBITS-1:8]};
    end
  assign {num2, num1} = lanes;
endmodule

// File: rtl/posit_batch_sequencer.sv
// posit_batch_sequencer: runs the posit unit over a batch of operand pairs in on-chip memory
//   clock/reset : single clock, asynchronous active-high reset
//   start/count : HPS run request (rising edge) and number of pairs
//   busy/completed/err : batch status back to the HPS
//   bus         : operand read port, result write port and posit unit handshake
module posit_batch_sequencer import posit_seq_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NBITS = DEF_NBITS,
  parameter int RD_LAT = 1
) (
  input logic clock,
  input logic reset,
  input logic start,
  input logic [ADDR_W-3:0] count,
  output logic busy,
  output logic completed,
  output logic err,
  posit_batch_sequencer_if.master bus
);
  localparam int W = bytes_per_word(NBITS);
  localparam int KW = $clog2(2 * W + RD_LAT);
  localparam logic [ADDR_W-3:0] MAXP = (ADDR_W-2)'(max_pairs(ADDR_W));
  state_t state, nxt;
  logic start_q;
  logic [ADDR_W-3:0] cnt_q, idx;
  logic [KW-1:0] k;
  logic [NBITS-1:0] res;
  logic [NBITS-1:0] num1, num2;
  logic trig, bad_count, fetch_issue, last_fetch, last_write, last_pair, wr;
  assign trig = start & ~start_q;
  assign bad_count = count > MAXP;
  assign fetch_issue = state == FETCH && k < KW'(2 * W);
  // FETCH runs RD_LAT extra cycles so the last byte lands before ISSUE
  assign last_fetch = k == KW'(2 * W + RD_LAT - 1);
  assign last_write = k == KW'(W - 1);
  assign last_pair = (idx + (ADDR_W-2)'(1)) == cnt_q;
  assign wr = state == WRITE;
  posit_seq_byte_gather #(.NBITS(NBITS), .RD_LAT(RD_LAT)) u_gather (
    .clk(clock),
    .rst(reset),
    .issue(fetch_issue),
    .rd_data(bus.src_readdata),
    .num1(num1),
    .num2(num2)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !trig ? IDLE : (bad_count || count == '0) ? DONE : FETCH;
      FETCH: nxt = last_fetch ? ISSUE : FETCH;
      ISSUE: nxt = bus.pu_in_ready ? WAIT : ISSUE;
      WAIT: nxt = bus.pu_out_valid ? WRITE : WAIT;
      WRITE: nxt = last_write ? NEXT : WRITE;
      NEXT: nxt = last_pair ? DONE : FETCH;
      DONE: nxt = start ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.src_address = fetch_issue ? ADDR_W'(idx) * ADDR_W'(2 * W) + ADDR_W'(k) : '0;
    bus.src_chipselect = fetch_issue;
    bus.src_clken = fetch_issue;
    bus.src_write = 1'b0;
    bus.src_writedata = '0;
    bus.dst_address = wr ? ADDR_W'(idx) * ADDR_W'(W) + ADDR_W'(k) : '0;
    bus.dst_writedata = wr ? 8'(res >> {k, 3'b000}) : '0;
    bus.dst_write = wr;
    bus.dst_chipselect = wr;
    bus.dst_clken = wr;
    bus.pu_num1 = num1;
    bus.pu_num2 = num2;
    bus.pu_in_valid = state == ISSUE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      start_q <= 1'b0;
      cnt_q <= '0;
      idx <= '0;
      k <= '0;
      res <= '0;
      busy <= 1'b0;
      completed <= 1'b0;
      err <= 1'b0;
    end else begin
      start_q <= start;
      k <= (nxt == state && (state == FETCH || state == WRITE)) ? k + KW'(1) : '0;
      if (state == IDLE && trig) begin
        cnt_q <= count;
        idx <= '0;
        err <= bad_count;
      end
      if (state == NEXT && nxt == FETCH) idx <= idx + (ADDR_W-2)'(1);
      if (state == WAIT && bus.pu_out_valid) res <= bus.pu_result;
      busy <= nxt != IDLE && nxt != DONE;
      // completed and err drop on the same edge that leaves DONE
      completed <= state == DONE && start;
      if (state == DONE && !start) err <= 1'b0;
    end
endmodule

// File: tb/tb_posit_batch_sequencer.sv
// tb_posit_batch_sequencer: scoreboard bench with byte memories and an XOR posit-unit stub
module tb_posit_batch_sequencer;
  localparam int L = 3;
  logic clock = 0;
  logic reset = 1;
  logic start = 0;
  logic [9:0] count = '0;
  logic busy, completed, err;
  logic stall = 0;
  int n_cmp = 0, n_bad = 0;
  int n_acc = 0, n_wr = 0, n_rd = 0;
  logic [11:0] last_wr = '0;
  logic [7:0] src_mem [4096];
  logic [7:0] dst_mem [4096];
  logic [63:0] exp_ops [$];
  logic [19:0] exp_wr [$];
  logic [1:0] pcnt;
  logic ov;
  logic [31:0] pres;

  posit_batch_sequencer_if #(.ADDR_W(12), .NBITS(32)) bus ();

  posit_batch_sequencer #(.ADDR_W(12), .NBITS(32), .RD_LAT(1)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .count(count),
    .busy(busy),
    .completed(completed),
    .err(err),
    .bus(bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (bus.src_chipselect && bus.src_clken) bus.src_readdata <= src_mem[bus.src_address];

  always @(posedge clock)
    if (bus.dst_write && bus.dst_chipselect && bus.dst_clken) dst_mem[bus.dst_address] <= bus.dst_writedata;

  assign bus.pu_in_ready = !stall;
  assign bus.pu_out_valid = ov;
  assign bus.pu_result = pres;

  always @(posedge clock or posedge reset)
    if (reset) begin
      pcnt <= '0;
      ov <= 1'b0;
      pres <= '0;
    end else begin
      ov <= pcnt == 2'd1;
      if (bus.pu_in_valid && bus.pu_in_ready) begin
        pcnt <= 2'(L - 1);
        pres <= bus.pu_num1 ^ bus.pu_num2;
      end else if (pcnt != 0) pcnt <= pcnt - 2'd1;
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock)
    if (!reset) begin
      if (bus.src_chipselect) n_rd++;
      if (bus.pu_in_valid && bus.pu_in_ready) begin
        n_acc++;
        if (exp_ops.size() == 0) check("ops_extra", 1, 0);
        else check("ops", {bus.pu_num2, bus.pu_num1}, exp_ops.pop_front());
      end
      if (bus.dst_write && bus.dst_chipselect && bus.dst_clken) begin
        n_wr++;
        last_wr = bus.dst_address;
        if (exp_wr.size() == 0) check("wr_extra", 1, 0);
        else check("wr", {bus.dst_address, bus.dst_writedata}, exp_wr.pop_front());
      end
    end

  function automatic logic [49:0] outs();
    return {busy, completed, err, bus.src_chipselect, bus.src_clken, bus.src_write,
            bus.dst_write, bus.dst_chipselect, bus.dst_clken, bus.pu_in_valid,
            bus.src_address, bus.dst_address, bus.src_writedata, bus.dst_writedata};
  endfunction

  task automatic push_pair(input int i);
    logic [31:0] a, b, r;
    for (int j = 0; j < 4; j++) begin
      a[8*j +: 8] = src_mem[8*i + j];
      b[8*j +: 8] = src_mem[8*i + 4 + j];
    end
    exp_ops.push_back({b, a});
    r = a ^ b;
    for (int j = 0; j < 4; j++) exp_wr.push_back({12'(4*i + j), r[8*j +: 8]});
  endtask

  task automatic load(input int n);
    for (int i = 0; i < 8*n; i++) src_mem[i] = 8'($urandom);
    for (int i = 0; i < n; i++) push_pair(i);
  endtask

  task automatic do_start(input int n);
    @(posedge clock);
    #1 count = 10'(n);
    start = 1;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!completed && cyc < budget) begin
      @(posedge clock);
      #1 cyc++;
    end
    check("done_reached", completed, 1);
  endtask

  task automatic drop_start();
    start = 0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, b_wr, b_rd, b_acc;
    repeat (3) @(negedge clock);
    check("rst_outs", outs(), 0);
    check("rst_nums", {bus.pu_num2, bus.pu_num1}, 0);
    @(posedge clock);
    #1 reset = 0;
    // single pair, fixed operands
    src_mem[0] = 8'h01; src_mem[1] = 8'h00; src_mem[2] = 8'h00; src_mem[3] = 8'h40;
    src_mem[4] = 8'h00; src_mem[5] = 8'h00; src_mem[6] = 8'h80; src_mem[7] = 8'h3F;
    exp_ops.push_back({32'h3F800000, 32'h40000001});
    exp_wr.push_back({12'd0, 8'h01});
    exp_wr.push_back({12'd1, 8'h00});
    exp_wr.push_back({12'd2, 8'h80});
    exp_wr.push_back({12'd3, 8'h7F});
    b_rd = n_rd;
    do_start(1);
    wait_done(100, cyc);
    check("t1_latency", cyc, 20);
    check("t1_err", err, 0);
    check("t1_busy", busy, 0);
    check("t1_reads", n_rd - b_rd, 8);
    check("t1_mem", {dst_mem[3], dst_mem[2], dst_mem[1], dst_mem[0]}, 32'h7F800001);
    drop_start();
    check("t1_clr", completed, 0);
    // zero pairs
    b_wr = n_wr;
    do_start(0);
    wait_done(20, cyc);
    check("t2_latency", cyc, 2);
    check("t2_err", err, 0);
    check("t2_writes", n_wr - b_wr, 0);
    drop_start();
    check("t2_clr", completed, 0);
    // out-of-range count
    b_wr = n_wr;
    b_rd = n_rd;
    do_start(513);
    wait_done(20, cyc);
    check("t3_latency", cyc, 2);
    check("t3_err", err, 1);
    check("t3_reads", n_rd - b_rd, 0);
    check("t3_writes", n_wr - b_wr, 0);
    drop_start();
    check("t3_err_clr", {completed, err}, 0);
    // maximum count fills the whole result region
    load(512);
    b_wr = n_wr;
    do_start(512);
    wait_done(12000, cyc);
    check("t4_last_addr", last_wr, 2047);
    check("t4_writes", n_wr - b_wr, 2048);
    check("t4_busy", busy, 0);
    check("t4_q_left", exp_ops.size() + exp_wr.size(), 0);
    drop_start();
    // posit unit back-pressure
    load(2);
    b_acc = n_acc;
    stall = 1;
    do_start(2);
    cyc = 0;
    while (!bus.pu_in_valid && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("t5_vld", bus.pu_in_valid, 1);
      check("t5_ops", {bus.pu_num2, bus.pu_num1}, exp_ops[0]);
    end
    check("t5_no_acc", n_acc - b_acc, 0);
    @(posedge clock);
    #1 stall = 0;
    wait_done(200, cyc);
    check("t5_accepts", n_acc - b_acc, 2);
    drop_start();
    // reset in WAIT of pair 2, then a clean rerun
    load(4);
    b_acc = n_acc;
    b_wr = n_wr;
    do_start(4);
    cyc = 0;
    while (n_acc - b_acc < 3 && cyc < 200) begin
      @(posedge clock);
      #1 cyc++;
    end
    check("t6_reach", n_acc - b_acc, 3);
    reset = 1;
    start = 0;
    @(negedge clock);
    check("t6_rst_outs", outs(), 0);
    check("t6_rst_nums", {bus.pu_num2, bus.pu_num1}, 0);
    check("t6_partial_wr", n_wr - b_wr, 8);
    repeat (2) @(posedge clock);
    #1 reset = 0;
    exp_ops.delete();
    exp_wr.delete();
    for (int i = 0; i < 4; i++) push_pair(i);
    b_acc = n_acc;
    b_wr = n_wr;
    do_start(4);
    wait_done(200, cyc);
    check("t6_accepts", n_acc - b_acc, 4);
    check("t6_writes", n_wr - b_wr, 16);
    drop_start();
    // no retrigger while busy or while start stays high in DONE
    load(2);
    b_wr = n_wr;
    do_start(2);
    repeat (3) @(posedge clock);
    #1 start = 0;
    @(posedge clock);
    #1 start = 1;
    check("t7_busy", busy, 1);
    wait_done(200, cyc);
    repeat (30) @(posedge clock);
    #1;
    check("t7_hold", {completed, busy}, 2'b10);
    check("t7_writes", n_wr - b_wr, 8);
    drop_start();
    repeat (5) @(posedge clock);
    #1;
    check("t7_after", {completed, busy, err}, 0);
    check("t7_writes_end", n_wr - b_wr, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/posit_batch_sequencer.md
Name: posit_batch_sequencer

Overview:
- Sequences the FPGA-side posit arithmetic unit over a batch of operand pairs held in on-chip memory.
- Operand memory: 4 KiB, byte-wide, dual-port, filled by the HPS.
- Per pair: fetch two 32-bit operands over the operand memory's second port, hand them to the posit unit with a valid/ready handshake, then write the 32-bit result byte-wise to the result memory's second port.
- Started and acknowledged through the HPS start/completed PIO pair.

Parameters:
- ADDR_W, 12, byte address width of both on-chip memories (4096 bytes).
- NBITS, 32, posit operand/result width. Must be a multiple of 8.
- RD_LAT, 1, operand-memory read latency in cycles. Legal values: 1 or 2.

Ports:
- clock  in  1  single clock for all logic and both memory ports
- reset  in  1  asynchronous, active-high
- start  in  1  run request from the HPS PIO, level signal; rising edge starts a batch
- count  in  ADDR_W-2  number of operand pairs; legal range 0..2^(ADDR_W-3)
- busy  out  1  high from batch start until DONE is entered
- completed  out  1  batch-finished flag to the HPS PIO
- err  out  1  count out of range; valid while completed=1
- src_address  out  ADDR_W  operand memory byte address
- src_chipselect  out  1  operand memory chip select
- src_clken  out  1  operand memory clock enable
- src_write  out  1  operand memory write strobe; tied 0
- src_writedata  out  8  operand memory write data; tied 0
- src_readdata  in  8  operand memory read data
- dst_address  out  ADDR_W  result memory byte address
- dst_chipselect  out  1  result memory chip select
- dst_clken  out  1  result memory clock enable
- dst_write  out  1  result memory write strobe
- dst_writedata  out  8  result memory write data
- pu_num1  out  NBITS  posit unit operand 1
- pu_num2  out  NBITS  posit unit operand 2
- pu_in_valid  out  1  operands valid to posit unit
- pu_in_ready  in  1  posit unit accepts operands
- pu_out_valid  in  1  posit unit result valid; one-cycle pulse
- pu_result  in  NBITS  posit unit result

Behaviour:
- Reset: FSM goes to IDLE. All outputs 0. Operand registers, pair index and start-edge register cleared. Reset asserted mid-batch abandons the batch immediately; partial result writes are not undone.
- Start detection: start_q registers start. Trigger = start & ~start_q, accepted only in IDLE; triggers in any other state are ignored.
- Memory layout, little-endian:
  - Pair i, W = NBITS/8: num1 bytes at 2W*i+0..W-1; num2 bytes at 2W*i+W..2W-1.
  - Result i: bytes at W*i+0..W-1.
  - Byte at the lowest address supplies bits [7:0].
- FSM states:
  - IDLE: on trigger, latch count. If count > 2^(ADDR_W-3), set err and go to DONE. If count = 0, go to DONE. Otherwise set busy, pair index i=0, go to FETCH.
  - FETCH: for issue cycles k=0..2W-1, drive src_address=2W*i+k with src_chipselect=src_clken=1. Byte k is captured into its operand lane RD_LAT cycles later. State lasts 2W+RD_LAT cycles, then go to ISSUE.
  - ISSUE: pu_in_valid=1 with stable pu_num1/pu_num2. Leave on the cycle pu_in_valid & pu_in_ready; go to WAIT.
  - WAIT: on pu_out_valid, latch pu_result and go to WRITE. pu_out_valid outside WAIT is ignored.
  - WRITE: cycles j=0..W-1 drive dst_address=W*i+j, dst_writedata=result[8j+7:8j], dst_write=dst_chipselect=dst_clken=1. Then go to NEXT.
  - NEXT: i+1 == count → DONE; otherwise i increments, go to FETCH.
  - DONE: busy=0, completed=1. Hold until start=0, then go to IDLE; completed and err clear on that transition.
- Timing: per-pair latency with a ready-always, L-cycle posit unit is (2W+RD_LAT)+1+L+W+1 cycles.
- Width rules: addresses computed modulo 2^ADDR_W. count range check prevents wrap for legal counts.

Decomposition:
- Package posit_seq_pkg:
  - state enum {IDLE, FETCH, ISSUE, WAIT, WRITE, NEXT, DONE}
  - constants BYTES_PER_WORD = NBITS/8 and MAX_PAIRS = 2^(ADDR_W-3)
- Sub-module posit_seq_byte_gather:
  - byte-lane shift/capture register with an RD_LAT-deep valid delay line
  - assembles num1/num2 from the byte stream

Test Plan:
- count=1; mem0 bytes 0..7 = 01 00 00 40 | 00 00 80 3F; posit unit stub returns num1^num2 after 3 cycles → pu_num1=0x40000001, pu_num2=0x3F800000; mem1[0..3] = 01 00 80 7F; completed rises 20 cycles after the start edge (RD_LAT=1).
- count=0 → completed=1 two cycles after the edge, err=0, no dst_write. Drop start → completed=0 next cycle.
- count=513 → err=1 and completed=1, no memory access. count=512 with a ready-always stub → last write to address 2047, busy low at end.
- pu_in_ready held low for 10 cycles → pu_in_valid and operands stable for all 10 cycles; a single accept follows.
- Assert reset during WAIT of pair 2 of 4 → all outputs 0 next cycle. A new start edge then runs pair 0 from scratch.
- Start held high after completion, plus a second edge while busy → no retrigger; exactly count×W dst writes in total.
